counter_ctrl: RTL and testbench
===============================

COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, consecutive cycles a synchronized button must differ from its stable state before the stable state changes; legal minimum 2.
REQ-002 Parameter TICK_DIV, default 5, tick period in clock cycles; legal minimum 2.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high; sampled on rising edge of clock.
REQ-005 btn_pause  input  1  raw asynchronous pushbutton, high = pressed.
REQ-006 btn_reverse  input  1  raw asynchronous pushbutton, high = pressed.
REQ-007 pause  output  1  registered level; drives the 7-segment counter's pause input.
REQ-008 reverse  output  1  registered level; drives the 7-segment counter's reverse input.
REQ-009 tick  output  1  one-cycle count-enable pulse for the 7-segment counter.

Function
REQ-010 Each button SHALL pass through its own 2-flop synchronizer; no other logic reads the raw input.
REQ-011 Each button SHALL have an independent debouncer: a stable bit and a counter wide enough to hold DEBOUNCE_CYCLES-1.
REQ-012 While sync == stable, the debounce counter SHALL be cleared to 0 every cycle.
REQ-013 While sync != stable and count < DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-014 While sync != stable and count == DEBOUNCE_CYCLES-1, stable SHALL take the sync value and the counter SHALL clear.
REQ-015 A 0->1 transition of a debounced stable bit SHALL invert the corresponding output (pause or reverse) on the next edge; 1->0 transitions SHALL have no effect.
REQ-016 Latency: if a raw button is first sampled high at edge k and held, its output SHALL toggle at edge k+3+DEBOUNCE_CYCLES (k+7 at default).
REQ-017 A raw pulse shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no toggle and leave stable unchanged.
REQ-018 A button held indefinitely SHALL produce exactly one toggle; release SHALL produce none.
REQ-019 The two channels SHALL be fully independent; simultaneous presses SHALL toggle both outputs on the same edge.
REQ-020 A tick divider SHALL count 0..TICK_DIV-1 and wrap to 0; it SHALL advance by 1 each cycle while pause == 0 and hold its value while pause == 1.
REQ-021 tick SHALL equal (divider == TICK_DIV-1) AND (pause == 0), decoded from registered state only.
REQ-022 When pause is released, the divider SHALL resume from its held value with no extra or skipped tick.
REQ-023 reverse SHALL have no effect on the divider or tick.

Reset
REQ-024 While reset is high at a rising edge: pause=0, reverse=0, divider=0, both synchronizers=0, both stable bits=0, both debounce counters=0; hence tick=0.
REQ-025 Reset SHALL dominate all other activity in the same cycle, including a pending stable-bit update or toggle.
REQ-026 Reset mid-debounce SHALL discard partial counts; debouncing restarts from 0 after deassertion.
REQ-027 After reset deasserts at edge r, the first tick SHALL be high during the cycle following edge r+TICK_DIV-1, then every TICK_DIV cycles.

Verification (DEBOUNCE_CYCLES=4, TICK_DIV=5)
REQ-028 Reset high 3 cycles, buttons low -> pause=0, reverse=0, tick=0 throughout; after release tick high 1 cycle in 5, first after 4 edges.
REQ-029 btn_pause high from edge k for 20 cycles -> pause 0->1 at edge k+7, stays 1; tick 0 while paused; release -> no change; second identical press -> pause 1->0, tick resumes after the remaining count of the held divider value.
REQ-030 btn_reverse high for 3 cycles then low -> reverse stays 0; same button high for 10 cycles -> reverse 0->1 at edge k+7, tick cadence unaffected.
REQ-031 Both buttons rise at edge k, held 10 cycles -> pause and reverse both 0->1 at edge k+7.
REQ-032 btn_pause high at edge k, low at k+4, reset high at edges k+5..k+6 -> pause remains 0, no later toggle, all state at reset values.
REQ-033 Bounce pattern 1,0,1,1,0,1,1,1,1,1 on btn_pause -> exactly one toggle, 7 edges after the final low-to-high transition.

Source files
------------

// File: rtl/counter_ctrl.sv
// counter_ctrl: conditions two raw pushbuttons into toggled pause/reverse levels and
// generates the count-enable tick for a downstream 7-segment counter.
// Each button path: 2-flop synchronizer -> debouncer -> registered press pulse -> toggle.
// The press pulse is registered so the output changes DEBOUNCE_CYCLES+3 edges after
// the raw input is first sampled high.
module counter_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TICK_DIV        = 5
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_btn_pause,
  input  logic i_btn_reverse,
  output logic o_pause,
  output logic o_reverse,
  output logic o_tick
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned DivW = $clog2(TICK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DivW-1:0] DivMax = DivW'(TICK_DIV - 1);

  // Channel 0 = pause, channel 1 = reverse.
  logic [1:0] w_btn_raw;
  logic [1:0] w_level;

  assign w_btn_raw = {i_btn_reverse, i_btn_pause};

  for (genvar g = 0; g < 2; g++) begin : g_chan
    logic            r_sync1;
    logic            r_sync2;
    logic            r_stable;
    logic            r_stable_d;
    logic            r_press;
    logic            r_level;
    logic [CntW-1:0] r_cnt;

    // Synchronize, debounce, register the rising edge of the stable bit, toggle the level.
    always_ff @(posedge i_clock) begin
      if (i_reset) begin
        r_sync1    <= 1'b0;
        r_sync2    <= 1'b0;
        r_stable   <= 1'b0;
        r_stable_d <= 1'b0;
        r_press    <= 1'b0;
        r_level    <= 1'b0;
        r_cnt      <= '0;
      end else begin
        r_sync1 <= w_btn_raw[g];
        r_sync2 <= r_sync1;
        if (r_sync2 == r_stable) begin
          r_cnt <= '0;
        end else if (r_cnt == CntMax) begin
          r_stable <= r_sync2;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        r_stable_d <= r_stable;
        // Only presses count; releases leave the level alone.
        r_press    <= r_stable & ~r_stable_d;
        if (r_press) begin
          r_level <= ~r_level;
        end
      end
    end

    assign w_level[g] = r_level;
  end

  assign o_pause   = w_level[0];
  assign o_reverse = w_level[1];

  logic [DivW-1:0] r_div;

  // Tick divider: wraps 0..TICK_DIV-1, frozen while paused so resume loses no phase.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_div <= '0;
    end else if (!o_pause) begin
      if (r_div == DivMax) begin
        r_div <= '0;
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  assign o_tick = (r_div == DivMax) && !o_pause;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl at DEBOUNCE_CYCLES=4, TICK_DIV=5.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Toggle edges are hand-placed: a press first sampled at step 0 toggles at step 7.
module tb_counter_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic btn_pause = 1'b0;
  logic btn_reverse = 1'b0;
  logic pause;
  logic reverse;
  logic tick;

  int n_vec = 0;
  int n_miss = 0;

  // Expected state: levels toggled by hand, divider phase tracked (advances when not paused).
  logic exp_pause = 1'b0;
  logic exp_rev = 1'b0;
  int   exp_div = 0;

  logic bounce [10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  counter_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .TICK_DIV(5)
  ) dut (
    .i_clock(clock),
    .i_reset(reset),
    .i_btn_pause(btn_pause),
    .i_btn_reverse(btn_reverse),
    .o_pause(pause),
    .o_reverse(reverse),
    .o_tick(tick)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s at %0t: observed %b expected %b", tag, $time, obs, exp);
    end
  endtask

  // One clock edge; tog_p/tog_r mark the edges where the outputs must flip.
  task automatic step(input string tag, input logic tog_p, input logic tog_r);
    @(posedge clock);
    #1;
    if (reset) begin
      exp_div   = 0;
      exp_pause = 1'b0;
      exp_rev   = 1'b0;
    end else begin
      if (!exp_pause) exp_div = (exp_div + 1) % 5;
      if (tog_p) exp_pause = ~exp_pause;
      if (tog_r) exp_rev = ~exp_rev;
    end
    chk({tag, ".pause"}, pause, exp_pause);
    chk({tag, ".reverse"}, reverse, exp_rev);
    chk({tag, ".tick"}, tick, (exp_div == 4) && !exp_pause);
  endtask

  initial begin
    // Reset for 3 cycles with buttons idle.
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step("reset", 1'b0, 1'b0);
    reset = 1'b0;
    // Free-running tick: first high after 4 edges, then every 5.
    for (int i = 0; i < 10; i++) step("cadence", 1'b0, 1'b0);

    // Pause press held 20 cycles, then released.
    btn_pause = 1'b1;
    for (int j = 0; j < 20; j++) step("pause_on", j == 7, 1'b0);
    btn_pause = 1'b0;
    for (int j = 0; j < 10; j++) step("pause_rel", 1'b0, 1'b0);
    // Second press resumes counting from the held divider value.
    btn_pause = 1'b1;
    for (int j = 0; j < 20; j++) step("pause_off", j == 7, 1'b0);
    btn_pause = 1'b0;
    for (int j = 0; j < 10; j++) step("pause_rel2", 1'b0, 1'b0);

    // Short reverse glitch: no toggle.
    btn_reverse = 1'b1;
    for (int j = 0; j < 3; j++) step("rev_short", 1'b0, 1'b0);
    btn_reverse = 1'b0;
    for (int j = 0; j < 10; j++) step("rev_short_rel", 1'b0, 1'b0);
    // Real reverse press: toggles reverse, tick cadence unaffected.
    btn_reverse = 1'b1;
    for (int j = 0; j < 10; j++) step("rev_on", 1'b0, j == 7);
    btn_reverse = 1'b0;
    for (int j = 0; j < 10; j++) step("rev_rel", 1'b0, 1'b0);

    // Simultaneous presses toggle both on the same edge.
    btn_pause   = 1'b1;
    btn_reverse = 1'b1;
    for (int j = 0; j < 10; j++) step("both", j == 7, j == 7);
    btn_pause   = 1'b0;
    btn_reverse = 1'b0;
    for (int j = 0; j < 10; j++) step("both_rel", 1'b0, 1'b0);

    // Return to reset state before the reset-dominance case.
    reset = 1'b1;
    for (int j = 0; j < 2; j++) step("reset2", 1'b0, 1'b0);
    reset = 1'b0;
    for (int j = 0; j < 3; j++) step("idle", 1'b0, 1'b0);

    // Press at k, low at k+4, reset at k+5..k+6: the pending stable update is discarded.
    btn_pause = 1'b1;
    for (int j = 0; j < 4; j++) step("mid_press", 1'b0, 1'b0);
    btn_pause = 1'b0;
    step("mid_low", 1'b0, 1'b0);
    reset = 1'b1;
    for (int j = 0; j < 2; j++) step("mid_reset", 1'b0, 1'b0);
    reset = 1'b0;
    for (int j = 0; j < 12; j++) step("mid_after", 1'b0, 1'b0);

    // Bounce: final low-to-high at step 5, toggle 7 edges later at step 12.
    for (int j = 0; j < 20; j++) begin
      btn_pause = (j < 10) ? bounce[j] : 1'b1;
      step("bounce", j == 12, 1'b0);
    end
    btn_pause = 1'b0;
    for (int j = 0; j < 10; j++) step("bounce_rel", 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
